// File: rtl/vram_write_ctrl.sv
// Write-side controller for the text-mode character RAM.
// Accepts host commands (put-char, cursor set, direct write, clear screen),
// turns them into single-cycle RAM write strobes and keeps a wrapping cursor
// over the visible COLS x ROWS area.
module vram_write_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int COLS   = 80,
    parameter int ROWS   = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    // Extended-width constants: cursor + COLS and the fill counter can exceed ADDR_W bits.
    localparam logic [ADDR_W:0]   N_X      = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [ADDR_W:0]   COLS_X   = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);

    localparam logic [1:0]        OP_PUTC   = 2'd0;
    localparam logic [1:0]        OP_SETPOS = 2'd1;
    localparam logic [1:0]        OP_CLEAR  = 2'd2;
    localparam logic [1:0]        OP_WRITE  = 2'd3;
    localparam logic [DATA_W-1:0] CH_CR     = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_LF     = DATA_W'(8'h0A);

    typedef enum logic [1:0] {IDLE, SEEK, CLEAR} state_t;

    state_t            state, state_next;
    logic              ready_next;
    logic              cea_next;
    logic [ADDR_W-1:0] ada_next;
    logic [DATA_W-1:0] din_next;
    logic [ADDR_W-1:0] cursor_next;
    logic [COL_W-1:0]  col, col_next;
    logic [ADDR_W-1:0] rem, rem_next;
    logic [ADDR_W:0]   fill_cnt, fill_next;
    logic [ADDR_W:0]   lf_sum;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;
    assign busy   = (state != IDLE);
    // Line-feed target, folded back into 0..N-1 when it runs past the last row.
    assign lf_sum = ({1'b0, cursor} + COLS_X >= N_X) ? ({1'b0, cursor} + COLS_X - N_X)
                                                    : ({1'b0, cursor} + COLS_X);

    // State and registered outputs; reset aborts any clear/seek in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            ram_cea   <= 1'b0;
            ram_ada   <= '0;
            ram_din   <= '0;
            cursor    <= '0;
            col       <= '0;
            rem       <= '0;
            fill_cnt  <= '0;
        end else begin
            state     <= state_next;
            cmd_ready <= ready_next;
            ram_cea   <= cea_next;
            ram_ada   <= ada_next;
            ram_din   <= din_next;
            cursor    <= cursor_next;
            col       <= col_next;
            rem       <= rem_next;
            fill_cnt  <= fill_next;
        end
    end

    // Next-state and next-output decode; ram_din holds the fill character during CLEAR.
    always_comb begin
        state_next  = state;
        ready_next  = cmd_ready;
        cea_next    = 1'b0;
        ada_next    = ram_ada;
        din_next    = ram_din;
        cursor_next = cursor;
        col_next    = col;
        rem_next    = rem;
        fill_next   = fill_cnt;
        case (state)
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            if (cmd_data == CH_CR) begin
                                cursor_next = cursor - {{(ADDR_W-COL_W){1'b0}}, col};
                                col_next    = '0;
                            end else if (cmd_data == CH_LF) begin
                                cursor_next = lf_sum[ADDR_W-1:0];
                            end else begin
                                cea_next    = 1'b1;
                                ada_next    = cursor;
                                din_next    = cmd_data;
                                col_next    = (col == COL_LAST) ? '0 : col + 1'b1;
                                cursor_next = (cursor == LAST) ? '0 : cursor + 1'b1;
                            end
                        end
                        OP_SETPOS: begin
                            if ({1'b0, cmd_addr} >= N_X) begin
                                cursor_next = '0;
                                col_next    = '0;
                            end else begin
                                cursor_next = cmd_addr;
                                rem_next    = cmd_addr;
                                state_next  = SEEK;
                                ready_next  = 1'b0;
                            end
                        end
                        OP_CLEAR: begin
                            cursor_next = '0;
                            col_next    = '0;
                            state_next  = CLEAR;
                            ready_next  = 1'b0;
                            cea_next    = 1'b1;
                            ada_next    = '0;
                            din_next    = cmd_data;
                            fill_next   = (ADDR_W+1)'(1);
                        end
                        OP_WRITE: begin
                            cea_next = 1'b1;
                            ada_next = cmd_addr;
                            din_next = cmd_data;
                        end
                        default: ;
                    endcase
                end
            end
            SEEK: begin
                // Repeated subtraction recovers the column without a divider.
                ready_next = 1'b0;
                if ({1'b0, rem} >= COLS_X) begin
                    rem_next = rem - COLS_X[ADDR_W-1:0];
                end else begin
                    col_next   = rem[COL_W-1:0];
                    state_next = IDLE;
                    ready_next = 1'b1;
                end
            end
            CLEAR: begin
                ready_next = 1'b0;
                if (fill_cnt == N_X) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end else begin
                    cea_next  = 1'b1;
                    ada_next  = fill_cnt[ADDR_W-1:0];
                    fill_next = fill_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Directed bench for vram_write_ctrl: a shadow RAM built from the write
// strobes plus a write log, compared against hand-computed expectations.
module tb_vram_write_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] ram_ada;
    logic [DATA_W-1:0] ram_din;
    logic              ram_cea;
    logic [ADDR_W-1:0] cursor;
    logic              busy;

    vram_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COLS(80), .ROWS(25)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .ram_ada(ram_ada), .ram_din(ram_din), .ram_cea(ram_cea),
        .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t  wq[$];
    logic [7:0] mem [0:2047];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    // Shadow RAM and write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_cea === 1'b1) begin
            mem[ram_ada] = ram_din;
            wq.push_back('{int'(ram_ada), int'(ram_din), cyc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Present a command at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] op, input int addr, input int data);
        int n;
        cmd_op    = op;
        cmd_addr  = addr[ADDR_W-1:0];
        cmd_data  = data[DATA_W-1:0];
        cmd_valid = 1'b1;
        wait_ready(n);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_cea", ram_cea, 0);
        chk("rst_ada", ram_ada, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // PUTC 'A','B' back to back
        wq.delete();
        send(2'd0, 0, 8'h41);
        chk("ready_putc_a", cmd_ready, 1);
        send(2'd0, 0, 8'h42);
        chk("ready_putc_b", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ab_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("a_addr", wq[0].a, 0);
            chk("a_data", wq[0].d, 8'h41);
            chk("b_addr", wq[1].a, 1);
            chk("b_data", wq[1].d, 8'h42);
            chk("ab_consec", wq[1].c - wq[0].c, 1);
        end
        chk("ab_cursor", cursor, 2);

        // SETPOS 1999, PUTC 'Z' wraps cursor and column
        send(2'd1, 1999, 0);
        cmd_valid = 1'b0;
        chk("seek_cursor", cursor, 1999);
        chk("seek_busy", busy, 1);
        wait_ready(n);
        chk("seek1999_len", n, 25);
        wq.delete();
        send(2'd0, 0, 8'h5A);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("z_count", wq.size(), 1);
        if (wq.size() == 1) chk("z_addr", wq[0].a, 1999);
        chk("z_wrap", cursor, 0);
        send(2'd0, 0, 8'h71);
        send(2'd0, 0, 8'h0D);
        cmd_valid = 1'b0;
        chk("col_wrapped", cursor, 0);

        // SETPOS 165, CR, LF, PUTC 'x'
        send(2'd1, 165, 0);
        cmd_valid = 1'b0;
        wait_ready(n);
        chk("seek165_len", n, 3);
        wq.delete();
        send(2'd0, 0, 8'h0D);
        chk("cr_cursor", cursor, 160);
        send(2'd0, 0, 8'h0A);
        chk("lf_cursor", cursor, 240);
        send(2'd0, 0, 8'h78);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("x_count", wq.size(), 1);
        if (wq.size() == 1) begin
            chk("x_addr", wq[0].a, 240);
            chk("x_data", wq[0].d, 8'h78);
        end
        chk("x_cursor", cursor, 241);
        send(2'd1, 1960, 0);
        cmd_valid = 1'b0;
        wait_ready(n);
        send(2'd0, 0, 8'h0A);
        cmd_valid = 1'b0;
        chk("lf_wrap", cursor, 40);

        // Out-of-range SETPOS and unchecked WRITE
        send(2'd1, 2000, 0);
        cmd_valid = 1'b0;
        chk("setpos_oor_cursor", cursor, 0);
        chk("setpos_oor_busy", busy, 0);
        chk("setpos_oor_ready", cmd_ready, 1);
        send(2'd0, 0, 8'h0A);
        send(2'd0, 0, 8'h0D);
        chk("setpos_oor_col", cursor, 80);
        wq.delete();
        send(2'd3, 2047, 8'h99);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wr_count", wq.size(), 1);
        if (wq.size() == 1) begin
            chk("wr_addr", wq[0].a, 2047);
            chk("wr_data", wq[0].d, 8'h99);
        end
        chk("wr_cursor", cursor, 80);

        // CLEAR with fill 0x20 while a PUTC 'Q' waits on the interface
        wq.delete();
        send(2'd2, 0, 8'h20);
        chk("clr_cursor", cursor, 0);
        chk("clr_busy", busy, 1);
        cmd_op    = 2'd0;
        cmd_data  = 8'h51;
        cmd_valid = 1'b1;
        wait_ready(n);
        chk("clr_ready_low", n, 2000);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("clr_count", wq.size(), 2001);
        if (wq.size() == 2001) begin
            bad = 0;
            for (int i = 0; i < 2000; i++) begin
                if (wq[i].a != i || wq[i].d != 8'h20) bad++;
                if (i > 0 && wq[i].c != wq[i-1].c + 1) bad++;
            end
            chk("clr_order", bad, 0);
            chk("q_addr", wq[2000].a, 0);
            chk("q_data", wq[2000].d, 8'h51);
            chk("q_gap", wq[2000].c - wq[1999].c, 2);
        end
        chk("q_cursor", cursor, 1);
        chk("clr_untouched", mem[2047], 8'h99);

        // Reset during CLEAR write #500
        send(2'd2, 0, 8'h2E);
        cmd_valid = 1'b0;
        n = 0;
        while (!(ram_cea === 1'b1 && ram_ada == 11'd499) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) chk("abort_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cea", ram_cea, 0);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_cursor", cursor, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 500; i++) if (mem[i] != 8'h2E) bad++;
        chk("abort_filled", bad, 0);
        chk("abort_500", mem[500], 8'h20);
        chk("abort_1999", mem[1999], 8'h20);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", cmd_ready, 1);
        wq.delete();
        send(2'd0, 0, 8'h6B);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_count", wq.size(), 1);
        if (wq.size() == 1) chk("post_addr", wq[0].a, 0);
        chk("post_cursor", cursor, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_write_ctrl.md
# vram_write_ctrl

Write-side controller for the 2048×8 text-mode character RAM; it owns the RAM's write port exclusively. It accepts host commands over a valid/ready interface: put-char at cursor, control characters, set cursor, direct write, and clear screen. It turns each command into single-cycle RAM write strobes and maintains a wrapping cursor over the visible COLS×ROWS area. The VGA scan-out logic keeps the RAM read port and is unaffected.

## Interface
- ADDR_W, 11, RAM address width
- DATA_W, 8, character width
- COLS, 80, characters per row
- ROWS, 25, rows; COLS*ROWS (N = 2000) must be ≤ 2^ADDR_W
- clk  in  1  single clock; also drives the RAM write-port clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (registered)
- cmd_op  in  2  0 PUTC, 1 SETPOS, 2 CLEAR, 3 WRITE
- cmd_addr  in  ADDR_W  target address for SETPOS and WRITE
- cmd_data  in  DATA_W  character for PUTC and WRITE; fill character for CLEAR
- ram_ada  out  ADDR_W  RAM write address (registered)
- ram_din  out  DATA_W  RAM write data (registered)
- ram_cea  out  1  RAM write enable, one cycle per write (registered)
- cursor  out  ADDR_W  current linear cursor, 0..N-1
- busy  out  1  high in SEEK or CLEAR

## Operation
- A command is accepted on a rising edge where cmd_valid && cmd_ready. Inputs are sampled only at acceptance.
- Internal state: linear cursor, column counter col (0..COLS-1), FSM {IDLE, SEEK, CLEAR}.
- PUTC, printable character (not 0x0D/0x0A):
  - Write cmd_data at cursor.
  - Advance: col==COLS-1 → col=0, else col+1.
  - cursor==N-1 → 0, else cursor+1.
- PUTC 0x0D (CR): no write; cursor -= col, col = 0.
- PUTC 0x0A (LF): no write; cursor += COLS; if the result is ≥ N, subtract N. col unchanged.
- WRITE: write cmd_data at cmd_addr. Cursor and col unchanged. The address is not range-checked; any value 0..2^ADDR_W-1 is written.
- SETPOS:
  - If cmd_addr ≥ N: cursor=0, col=0, stay IDLE.
  - Otherwise: cursor=cmd_addr and enter SEEK with rem=cmd_addr.
  - Each SEEK cycle: if rem ≥ COLS then rem -= COLS; else col=rem and return to IDLE.
- CLEAR:
  - Enter CLEAR with cursor=0, col=0, fill counter=0.
  - Each CLEAR cycle writes cmd_data (latched) at the counter, then increments.
  - After writing address N-1, return to IDLE. Addresses N..2^ADDR_W-1 are not touched.
- cmd_ready is forced 0 on the accepting edge of SETPOS (in range) and CLEAR. It returns to 1 on the edge that re-enters IDLE.
- Only one outstanding command at a time. The FSM is the sole source of ram_cea; CLEAR and host writes cannot collide.

## Timing
- Reset (reset_n low, asynchronous): cmd_ready=0, ram_cea=0, ram_ada=0, ram_din=0, cursor=0, busy=0, FSM=IDLE.
- cmd_ready rises on the first clk edge after reset_n deasserts.
- Reset asserted mid-CLEAR or mid-SEEK aborts immediately:
  - ram_cea drops asynchronously; partially cleared RAM contents remain.
  - cursor and col return to 0.
- PUTC printable / WRITE accepted at edge k:
  - ram_cea=1 with ram_ada/ram_din valid for exactly the cycle after edge k.
  - cursor updated at edge k.
  - cmd_ready stays 1, so back-to-back commands give one write per cycle.
- CR/LF: ram_cea stays 0; cursor updated at the accepting edge.
- SETPOS in range: SEEK lasts floor(cmd_addr/COLS)+1 cycles. cursor output is updated at acceptance; col is valid when cmd_ready returns.
- CLEAR accepted at edge k:
  - Exactly N consecutive cycles with ram_cea=1, addresses 0..N-1 in order.
  - cmd_ready=0 and busy=1 for those N cycles.
  - cmd_ready=1 in the cycle after the write to address N-1.
- The RAM's read-port latency is irrelevant here; writes land on the clk edge that ends the ram_cea cycle.

## Test plan
- Reset release, then PUTC 'A','B' back-to-back → writes (0,0x41),(1,0x42) on consecutive cycles; cursor=2; cmd_ready never drops.
- SETPOS 1999, then PUTC 'Z' → write at 1999; cursor wraps to 0, col=0. SEEK lasts 25 cycles.
- SETPOS 165, then CR, then LF, then PUTC 'x' → col=5 after SEEK; CR gives cursor 160; LF gives cursor 240; write at 240. From cursor 1960, LF gives cursor 40.
- CLEAR with fill 0x20 → 2000 consecutive writes of 0x20 at 0..1999; no write at ≥2000; cmd_ready low for exactly 2000 cycles; cursor=0.
- cmd_valid held high with PUTC during a CLEAR → no accept until cmd_ready rises; the queued character is then written at address 0.
- reset_n pulsed low at CLEAR write #500 → ram_cea drops at once; cmd_ready=0 during reset; RAM addresses 0..499 hold the fill character; cursor=0 after release.
